ph_ram_arbiter: RTL and testbench

Parametrised N-port arbiter that shares one physical RAM port (ph_* bus) among several memory-controller-class requesters, e.g. multiple MemoryController instances in a multi-core CPU top.
- Generalises the single-requester physical RAM connection to NUM_PORTS channels with configurable address and data widths.
- Adds round-robin fairness, a per-transaction timeout with error reporting, and debug counters.
- Sits between the requesters and the external RAM interface; exactly one transaction is outstanding at a time.

---
 rtl/ph_ram_arbiter_pkg.sv | 36 +++
 rtl/ph_ram_arbiter_if.sv | 39 +++
 rtl/ph_ram_arbiter_picker.sv | 22 ++
 rtl/ph_ram_arbiter.sv | 157 +++++++++++++++
 tb/tb_ph_ram_arbiter.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ph_ram_arbiter_pkg.sv
// Shared types, default widths and the round-robin pick function for the
// physical RAM arbiter and its priority picker.
package ph_arb_pkg;

    localparam int MAX_PORTS          = 16;
    localparam int PICK_W             = 4;
    localparam int DEF_NUM_PORTS      = 2;
    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    // Returns the first requesting index found when scanning ptr, ptr+1, ...
    // modulo n. Returns 0 when nothing requests; callers qualify with |req.
    function automatic int unsigned rr_pick(input logic [MAX_PORTS-1:0] req,
                                            input int unsigned ptr,
                                            input int unsigned n);
        int unsigned idx;
        logic found;
        rr_pick = 0;
        found   = 1'b0;
        for (int unsigned k = 0; k < MAX_PORTS; k++) begin
            idx = (n == 0) ? 0 : (ptr + k) % n;
            if (!found && (k < n) && req[PICK_W'(idx)]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/ph_ram_arbiter_if.sv
// Bundle of the requester-side and physical-RAM-side signals of the arbiter.
// The arbiter sits on the slave modport; the requesters and RAM model sit on
// the master modport.
interface ph_ram_arbiter_if
    import ph_arb_pkg::*;
#(
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic [NUM_PORTS-1:0]            port_req;
    logic [NUM_PORTS-1:0]            port_we;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0] port_wdata;
    logic [DATA_WIDTH-1:0]           port_rdata;
    logic [NUM_PORTS-1:0]            port_ack;
    logic                            port_err;

    logic                            ph_request;
    logic                            ph_write_enable;
    logic [ADDR_WIDTH-1:0]           ph_ram_address;
    logic [DATA_WIDTH-1:0]           ph_ram_write;
    logic [DATA_WIDTH-1:0]           ph_ram_read;
    logic                            ph_ack;

    modport master (
        output port_req, port_we, port_addr, port_wdata, ph_ram_read, ph_ack,
        input  port_rdata, port_ack, port_err,
               ph_request, ph_write_enable, ph_ram_address, ph_ram_write
    );

    modport slave (
        input  port_req, port_we, port_addr, port_wdata, ph_ram_read, ph_ack,
        output port_rdata, port_ack, port_err,
               ph_request, ph_write_enable, ph_ram_address, ph_ram_write
    );

endinterface

// File: rtl/ph_ram_arbiter_picker.sv
// Combinational round-robin picker: rotates the request vector to start at
// ptr_i and priority-encodes the first set bit. Kept generic so other shared
// resources can reuse it.
module rr_priority_picker
    import ph_arb_pkg::*;
#(
    parameter  int NUM_PORTS = DEF_NUM_PORTS,
    localparam int GW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [GW-1:0]        ptr_i,
    output logic [GW-1:0]        grant_o,
    output logic                 valid_o
);

    // Pick the first requester at or after the pointer, wrapping around.
    always_comb begin
        grant_o = GW'(rr_pick(MAX_PORTS'(req_i), 32'(ptr_i), NUM_PORTS));
        valid_o = |req_i;
    end

endmodule

// File: rtl/ph_ram_arbiter.sv
// Shares one physical RAM port among NUM_PORTS requesters. One transaction is
// outstanding at a time; grants rotate round-robin, a stuck RAM is aborted
// after TIMEOUT_CYCLES busy cycles and reported through port_err.
module ph_ram_arbiter
    import ph_arb_pkg::*;
#(
    parameter  int NUM_PORTS      = DEF_NUM_PORTS,
    parameter  int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter  int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int GW             = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    ph_ram_arbiter_if.slave  bus,
    output logic [GW-1:0]    dbg_grant,
    output logic [7:0]       dbg_timeouts
);

    localparam int            TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TLAST      = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic          TIMEOUT_ON = (TIMEOUT_CYCLES != 0);
    localparam logic [GW-1:0] LAST_PORT  = GW'(NUM_PORTS - 1);

    arb_state_t              state_q, state_d;
    logic [GW-1:0]           rrPtr_q, rrPtr_d;
    logic [GW-1:0]           grant_q, grant_d;
    logic                    phReq_q, phReq_d;
    logic                    phWe_q, phWe_d;
    logic [ADDR_WIDTH-1:0]   phAddr_q, phAddr_d;
    logic [DATA_WIDTH-1:0]   phWdata_q, phWdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [NUM_PORTS-1:0]    ack_q, ack_d;
    logic                    err_q, err_d;
    logic [TW-1:0]           tcnt_q, tcnt_d;
    logic [7:0]              tmo_q, tmo_d;

    logic [GW-1:0]           pickGrant;
    logic                    pickValid;
    logic [GW-1:0]           nextPtr;
    logic                    timeoutHit;

    rr_priority_picker #(
        .NUM_PORTS (NUM_PORTS)
    ) u_picker (
        .req_i   (bus.port_req),
        .ptr_i   (rrPtr_q),
        .grant_o (pickGrant),
        .valid_o (pickValid)
    );

    assign nextPtr    = (grant_q == LAST_PORT) ? '0 : grant_q + 1'b1;
    assign timeoutHit = TIMEOUT_ON && (tcnt_q == TLAST);

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            rrPtr_q   <= '0;
            grant_q   <= '0;
            phReq_q   <= 1'b0;
            phWe_q    <= 1'b0;
            phAddr_q  <= '0;
            phWdata_q <= '0;
            rdata_q   <= '0;
            ack_q     <= '0;
            err_q     <= 1'b0;
            tcnt_q    <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            rrPtr_q   <= rrPtr_d;
            grant_q   <= grant_d;
            phReq_q   <= phReq_d;
            phWe_q    <= phWe_d;
            phAddr_q  <= phAddr_d;
            phWdata_q <= phWdata_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            tcnt_q    <= tcnt_d;
            tmo_q     <= tmo_d;
        end
    end

    // Next-state logic: grant in IDLE, wait for ack or timeout in BUSY (ack
    // wins a tie), and hold the completion pulse for one cycle in DONE.
    always_comb begin
        state_d   = state_q;
        rrPtr_d   = rrPtr_q;
        grant_d   = grant_q;
        phReq_d   = phReq_q;
        phWe_d    = phWe_q;
        phAddr_d  = phAddr_q;
        phWdata_d = phWdata_q;
        rdata_d   = rdata_q;
        ack_d     = ack_q;
        err_d     = err_q;
        tcnt_d    = tcnt_q;
        tmo_d     = tmo_q;
        case (state_q)
            IDLE: begin
                if (pickValid) begin
                    state_d   = BUSY;
                    grant_d   = pickGrant;
                    phReq_d   = 1'b1;
                    phWe_d    = bus.port_we[pickGrant];
                    phAddr_d  = bus.port_addr[int'(pickGrant)*ADDR_WIDTH +: ADDR_WIDTH];
                    phWdata_d = bus.port_wdata[int'(pickGrant)*DATA_WIDTH +: DATA_WIDTH];
                    tcnt_d    = '0;
                end
            end
            BUSY: begin
                if (bus.ph_ack) begin
                    state_d = DONE;
                    phReq_d = 1'b0;
                    ack_d   = NUM_PORTS'(1) << grant_q;
                    err_d   = 1'b0;
                    rdata_d = phWe_q ? '0 : bus.ph_ram_read;
                    rrPtr_d = nextPtr;
                end else if (timeoutHit) begin
                    state_d = DONE;
                    phReq_d = 1'b0;
                    ack_d   = NUM_PORTS'(1) << grant_q;
                    err_d   = 1'b1;
                    rdata_d = '0;
                    rrPtr_d = nextPtr;
                    tmo_d   = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                ack_d   = '0;
                err_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs come straight from registers so every output is 0 after reset.
    always_comb begin
        bus.ph_request      = phReq_q;
        bus.ph_write_enable = phWe_q;
        bus.ph_ram_address  = phAddr_q;
        bus.ph_ram_write    = phWdata_q;
        bus.port_rdata      = rdata_q;
        bus.port_ack        = ack_q;
        bus.port_err        = err_q;
        dbg_grant           = grant_q;
        dbg_timeouts        = tmo_q;
    end

endmodule

// File: tb/tb_ph_ram_arbiter.sv
// Directed bench for ph_ram_arbiter: a 2-port instance with an 8-cycle
// timeout and a 3-port instance with the timeout disabled.
module tb_ph_ram_arbiter;

    logic clk;
    logic rstN;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    ph_ram_arbiter_if #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) busA ();
    ph_ram_arbiter_if #(.NUM_PORTS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) busB ();

    logic [0:0] dbgGrantA;
    logic [7:0] dbgTimeoutsA;
    logic [1:0] dbgGrantB;
    logic [7:0] dbgTimeoutsB;

    ph_ram_arbiter #(
        .NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
    ) dutA (
        .clk          (clk),
        .reset        (rstN),
        .bus          (busA),
        .dbg_grant    (dbgGrantA),
        .dbg_timeouts (dbgTimeoutsA)
    );

    ph_ram_arbiter #(
        .NUM_PORTS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(0)
    ) dutB (
        .clk          (clk),
        .reset        (rstN),
        .bus          (busB),
        .dbg_grant    (dbgGrantB),
        .dbg_timeouts (dbgTimeoutsB)
    );

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] ramRead;
        int          delay;
        logic [1:0]  expAck;
        logic [31:0] expRdata;
        logic        expErr;
    } vec_t;

    vec_t vecs [4];
    int   passCount;
    int   checkCount;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic resetDuts();
        rstN             = 1'b0;
        busA.port_req    = '0;
        busA.port_we     = '0;
        busA.port_addr   = '0;
        busA.port_wdata  = '0;
        busA.ph_ram_read = '0;
        busA.ph_ack      = 1'b0;
        busB.port_req    = '0;
        busB.port_we     = '0;
        busB.port_addr   = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
        busB.port_wdata  = '0;
        busB.ph_ram_read = '0;
        busB.ph_ack      = 1'b0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
    endtask

    // One transaction on the 2-port instance from a table record.
    task automatic applyStimulus(input vec_t v);
        busA.port_req                        = '0;
        busA.port_we                         = '0;
        busA.port_req[v.port]                = 1'b1;
        busA.port_we[v.port]                 = v.we;
        busA.port_addr[v.port*32 +: 32]      = v.addr;
        busA.port_wdata[v.port*32 +: 32]     = v.wdata;
        busA.ph_ram_read                     = v.ramRead;
        busA.ph_ack                          = 1'b0;
        @(negedge clk);
        checkOutput("grant_ph_request", 64'(busA.ph_request), 64'd1);
        checkOutput("grant_write_enable", 64'(busA.ph_write_enable), 64'(v.we));
        checkOutput("grant_address", 64'(busA.ph_ram_address), 64'(v.addr));
        checkOutput("grant_write_data", 64'(busA.ph_ram_write), 64'(v.wdata));
        checkOutput("grant_dbg_grant", 64'(dbgGrantA), 64'(v.port));
        repeat (v.delay) @(negedge clk);
        checkOutput("busy_ph_request_held", 64'(busA.ph_request), 64'd1);
        checkOutput("busy_address_held", 64'(busA.ph_ram_address), 64'(v.addr));
        busA.ph_ack = 1'b1;
        @(negedge clk);
        checkOutput("done_port_ack", 64'(busA.port_ack), 64'(v.expAck));
        checkOutput("done_port_rdata", 64'(busA.port_rdata), 64'(v.expRdata));
        checkOutput("done_port_err", 64'(busA.port_err), 64'(v.expErr));
        checkOutput("done_ph_request_low", 64'(busA.ph_request), 64'd0);
        busA.ph_ack   = 1'b0;
        busA.port_req = '0;
        @(negedge clk);
        checkOutput("idle_port_ack_clear", 64'(busA.port_ack), 64'd0);
    endtask

    // One read on the 3-port instance with a given request mix.
    task automatic applyStimulusB(input logic [2:0] reqVec, input int expGrant,
                                  input int delay, input logic [31:0] ramRead);
        logic [2:0] expAck;
        expAck           = 3'b001 << expGrant;
        busB.port_req    = reqVec;
        busB.ph_ram_read = ramRead;
        busB.ph_ack      = 1'b0;
        @(negedge clk);
        checkOutput("b_ph_request", 64'(busB.ph_request), 64'd1);
        checkOutput("b_dbg_grant", 64'(dbgGrantB), 64'(expGrant));
        checkOutput("b_address", 64'(busB.ph_ram_address), 64'((expGrant + 1) * 32'h100));
        repeat (delay) @(negedge clk);
        checkOutput("b_ph_request_held", 64'(busB.ph_request), 64'd1);
        busB.ph_ack = 1'b1;
        @(negedge clk);
        checkOutput("b_port_ack", 64'(busB.port_ack), 64'(expAck));
        checkOutput("b_port_err", 64'(busB.port_err), 64'd0);
        checkOutput("b_port_rdata", 64'(busB.port_rdata), 64'(ramRead));
        busB.ph_ack   = 1'b0;
        busB.port_req = '0;
        @(negedge clk);
        checkOutput("b_port_ack_clear", 64'(busB.port_ack), 64'd0);
    endtask

    initial begin
        int cnt;
        int acks;
        passCount  = 0;
        checkCount = 0;
        rstN       = 1'b0;

        vecs[0] = '{0, 1'b0, 32'h0000_0100, 32'h0000_0000, 32'hDEAD_BEEF, 0, 2'b01, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{1, 1'b1, 32'h0000_0204, 32'hCAFE_F00D, 32'h1234_5678, 2, 2'b10, 32'h0000_0000, 1'b0};
        vecs[2] = '{0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0001, 5, 2'b01, 32'h0000_0001, 1'b0};
        vecs[3] = '{1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'hA5A5_A5A5, 7, 2'b10, 32'hA5A5_A5A5, 1'b0};

        @(negedge clk);
        resetDuts();
        $display("[TB] reset state");
        checkOutput("rst_ph_request", 64'(busA.ph_request), 64'd0);
        checkOutput("rst_port_ack", 64'(busA.port_ack), 64'd0);
        checkOutput("rst_port_err", 64'(busA.port_err), 64'd0);
        checkOutput("rst_port_rdata", 64'(busA.port_rdata), 64'd0);
        checkOutput("rst_write_enable", 64'(busA.ph_write_enable), 64'd0);
        checkOutput("rst_address", 64'(busA.ph_ram_address), 64'd0);
        checkOutput("rst_dbg_grant", 64'(dbgGrantA), 64'd0);
        checkOutput("rst_dbg_timeouts", 64'(dbgTimeoutsA), 64'd0);
        checkOutput("rst_b_ph_request", 64'(busB.ph_request), 64'd0);
        checkOutput("rst_b_port_ack", 64'(busB.port_ack), 64'd0);

        $display("[TB] stray ph_ack in IDLE");
        busA.ph_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checkOutput("stray_ph_request", 64'(busA.ph_request), 64'd0);
            checkOutput("stray_port_ack", 64'(busA.port_ack), 64'd0);
        end
        busA.ph_ack = 1'b0;

        $display("[TB] table vectors");
        for (int i = 0; i < 4; i++) applyStimulus(vecs[i]);

        $display("[TB] round-robin with both ports requesting");
        resetDuts();
        busA.ph_ram_read = 32'h5A5A_1234;
        busA.port_req    = 2'b11;
        busA.ph_ack      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("rr_dbg_grant", 64'(dbgGrantA), 64'(i % 2));
            checkOutput("rr_ph_request", 64'(busA.ph_request), 64'd1);
            @(negedge clk);
            checkOutput("rr_port_ack", 64'(busA.port_ack), (i % 2 == 1) ? 64'h2 : 64'h1);
            checkOutput("rr_port_rdata", 64'(busA.port_rdata), 64'h5A5A_1234);
            @(negedge clk);
            checkOutput("rr_port_ack_clear", 64'(busA.port_ack), 64'd0);
        end
        busA.port_req = '0;
        busA.ph_ack   = 1'b0;

        $display("[TB] timeout");
        busA.ph_ram_read = 32'h1111_1111;
        busA.port_req    = 2'b01;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busA.ph_request) cnt++;
            else break;
        end
        checkOutput("tmo_request_cycles", 64'(cnt), 64'd8);
        checkOutput("tmo_port_ack", 64'(busA.port_ack), 64'h1);
        checkOutput("tmo_port_err", 64'(busA.port_err), 64'd1);
        checkOutput("tmo_port_rdata", 64'(busA.port_rdata), 64'd0);
        checkOutput("tmo_dbg_timeouts", 64'(dbgTimeoutsA), 64'd1);
        @(negedge clk);
        checkOutput("tmo_port_ack_clear", 64'(busA.port_ack), 64'd0);
        checkOutput("tmo_port_err_clear", 64'(busA.port_err), 64'd0);

        acks = 1;
        for (int i = 0; i < 4000 && acks < 300; i++) begin
            @(negedge clk);
            if (busA.port_ack[0]) acks++;
        end
        busA.port_req = '0;
        checkOutput("tmo_ack_count", 64'(acks), 64'd300);
        checkOutput("tmo_saturated", 64'(dbgTimeoutsA), 64'd255);
        checkOutput("tmo_last_err", 64'(busA.port_err), 64'd1);
        @(negedge clk);

        $display("[TB] reset during BUSY");
        busA.port_req = 2'b10;
        @(negedge clk);
        checkOutput("mid_ph_request", 64'(busA.ph_request), 64'd1);
        checkOutput("mid_dbg_grant", 64'(dbgGrantA), 64'd1);
        rstN = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_ph_request", 64'(busA.ph_request), 64'd0);
        checkOutput("mid_rst_port_ack", 64'(busA.port_ack), 64'd0);
        checkOutput("mid_rst_port_err", 64'(busA.port_err), 64'd0);
        checkOutput("mid_rst_dbg_timeouts", 64'(dbgTimeoutsA), 64'd0);
        rstN          = 1'b1;
        busA.port_req = 2'b11;
        @(negedge clk);
        checkOutput("post_rst_ph_request", 64'(busA.ph_request), 64'd1);
        checkOutput("post_rst_grant", 64'(dbgGrantA), 64'd0);
        busA.ph_ram_read = 32'h0BAD_CAFE;
        busA.ph_ack      = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_port_ack", 64'(busA.port_ack), 64'h1);
        busA.ph_ack   = 1'b0;
        busA.port_req = '0;
        @(negedge clk);

        $display("[TB] three-port rotation");
        resetDuts();
        applyStimulusB(3'b100, 2, 0, 32'h0000_2222);
        applyStimulusB(3'b110, 1, 0, 32'h0000_1111);
        applyStimulusB(3'b100, 2, 1, 32'h0000_2223);
        applyStimulusB(3'b111, 0, 0, 32'h0000_0000);
        applyStimulusB(3'b101, 2, 0, 32'h0000_2224);
        applyStimulusB(3'b010, 1, 40, 32'h7777_0001);
        checkOutput("b_no_timeouts", 64'(dbgTimeoutsB), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
